// File: rtl/grav_pkg.sv
// Shared types and constants for the grav pair scheduler.
package grav_pkg;

  localparam int FP_W = 27;
  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RD_I,
    RD_J,
    CAP_J,
    WAIT,
    WB,
    DONE
  } state_t;

  typedef struct packed {
    logic [FP_W-1:0] x;
    logic [FP_W-1:0] y;
    logic [FP_W-1:0] m;
  } body_t;

endpackage

// File: rtl/grav_pair_iter.sv
// Lexicographic (i<j) body pair iterator: (0,1), (0,2), ... (N-2,N-1).
module grav_pair_iter #(
  parameter int N_BODIES = 4,
  parameter int IDX_W    = $clog2(N_BODIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last_pair
);

  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(N_BODIES - 2);
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N_BODIES - 1);

  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clear) begin
      i_d = '0;
      j_d = IDX_W'(1);
    end else if (advance) begin
      if (j_q != J_LAST) begin
        j_d = j_q + 1'b1;
      end else if (i_q != I_LAST) begin
        i_d = i_q + 1'b1;
        j_d = i_q + IDX_W'(2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i         = i_q;
  assign j         = j_q;
  assign last_pair = (i_q == I_LAST) && (j_q == J_LAST);

endmodule

// File: rtl/grav_pair_sched.sv
// Walks all body pairs, feeds each to grav, and stores the returned
// acceleration partial sums in an accumulator file with readback.
module grav_pair_sched
  import grav_pkg::*;
#(
  parameter int N_BODIES = 4,
  parameter int IDX_W    = $clog2(N_BODIES),
  parameter int GRAV_LAT = 18,
  parameter int FP_W     = grav_pkg::FP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] body_addr,
  input  logic [FP_W-1:0]  body_x,
  input  logic [FP_W-1:0]  body_y,
  input  logic [FP_W-1:0]  body_m,
  output logic [FP_W-1:0]  g_x1,
  output logic [FP_W-1:0]  g_y1,
  output logic [FP_W-1:0]  g_m1,
  output logic [FP_W-1:0]  g_x2,
  output logic [FP_W-1:0]  g_y2,
  output logic [FP_W-1:0]  g_m2,
  output logic [FP_W-1:0]  g_x1old_psum,
  output logic [FP_W-1:0]  g_y1old_psum,
  output logic [FP_W-1:0]  g_x2old_psum,
  output logic [FP_W-1:0]  g_y2old_psum,
  input  logic [FP_W-1:0]  g_x1new_psum,
  input  logic [FP_W-1:0]  g_y1new_psum,
  input  logic [FP_W-1:0]  g_x2new_psum,
  input  logic [FP_W-1:0]  g_y2new_psum,
  input  logic [IDX_W-1:0] acc_addr,
  output logic [FP_W-1:0]  acc_ax,
  output logic [FP_W-1:0]  acc_ay
);

  localparam int CNT_W = $clog2(GRAV_LAT + 1);

  state_t           state_q, state_d;
  body_t            bi_q, bi_d;
  body_t            bj_q, bj_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [FP_W-1:0]  x1o_q, x1o_d, y1o_q, y1o_d;
  logic [FP_W-1:0]  x2o_q, x2o_d, y2o_q, y2o_d;
  logic [FP_W-1:0]  acc_x_q [N_BODIES];
  logic [FP_W-1:0]  acc_x_d [N_BODIES];
  logic [FP_W-1:0]  acc_y_q [N_BODIES];
  logic [FP_W-1:0]  acc_y_d [N_BODIES];

  logic             it_clear, it_advance, last_pair;
  logic [IDX_W-1:0] pi, pj;

  grav_pair_iter #(
    .N_BODIES (N_BODIES),
    .IDX_W    (IDX_W)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .clear     (it_clear),
    .advance   (it_advance),
    .i         (pi),
    .j         (pj),
    .last_pair (last_pair)
  );

  always_comb begin
    state_d    = state_q;
    bi_d       = bi_q;
    bj_d       = bj_q;
    cnt_d      = cnt_q;
    x1o_d      = x1o_q;
    y1o_d      = y1o_q;
    x2o_d      = x2o_q;
    y2o_d      = y2o_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    it_clear   = 1'b0;
    it_advance = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = CLR;
      CLR: begin
        for (int unsigned n = 0; n < N_BODIES; n++) begin
          acc_x_d[n] = FP_ZERO;
          acc_y_d[n] = FP_ZERO;
        end
        it_clear = 1'b1;
        state_d  = RD_I;
      end
      RD_I:  state_d = RD_J;
      RD_J: begin
        bi_d    = {body_x, body_y, body_m};
        state_d = CAP_J;
      end
      CAP_J: begin
        bj_d    = {body_x, body_y, body_m};
        x1o_d   = acc_x_q[pi];
        y1o_d   = acc_y_q[pi];
        x2o_d   = acc_x_q[pj];
        y2o_d   = acc_y_q[pj];
        cnt_d   = CNT_W'(GRAV_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = WB;
      end
      WB: begin
        acc_x_d[pi] = g_x1new_psum;
        acc_y_d[pi] = g_y1new_psum;
        acc_x_d[pj] = g_x2new_psum;
        acc_y_d[pj] = g_y2new_psum;
        it_advance  = 1'b1;
        state_d     = last_pair ? DONE : RD_I;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bi_q    <= '0;
      bj_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x1o_q   <= FP_ZERO;
      y1o_q   <= FP_ZERO;
      x2o_q   <= FP_ZERO;
      y2o_q   <= FP_ZERO;
      acc_x_q <= '{default: FP_ZERO};
      acc_y_q <= '{default: FP_ZERO};
    end else begin
      state_q <= state_d;
      bi_q    <= bi_d;
      bj_q    <= bj_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x1o_q   <= x1o_d;
      y1o_q   <= y1o_d;
      x2o_q   <= x2o_d;
      y2o_q   <= y2o_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
    end
  end

  // Address is a pure mux of registered i/j so it tracks the iterator
  // in the same cycle the state enters RD_I/RD_J.
  assign body_addr = (state_q == RD_J) ? pj : pi;

  assign busy         = busy_q;
  assign done         = done_q;
  assign g_x1         = bi_q.x;
  assign g_y1         = bi_q.y;
  assign g_m1         = bi_q.m;
  assign g_x2         = bj_q.x;
  assign g_y2         = bj_q.y;
  assign g_m2         = bj_q.m;
  assign g_x1old_psum = x1o_q;
  assign g_y1old_psum = y1o_q;
  assign g_x2old_psum = x2o_q;
  assign g_y2old_psum = y2o_q;
  assign acc_ax       = acc_x_q[acc_addr];
  assign acc_ay       = acc_y_q[acc_addr];

endmodule

// File: tb/tb_grav_pair_sched.sv
// Scoreboard bench for grav_pair_sched with a fixed-latency stub grav.
module tb_grav_pair_sched;

  localparam int N        = 4;
  localparam int LAT      = 18;
  localparam int FW       = 27;
  localparam int AW       = $clog2(N);
  localparam int PAIRS    = N * (N - 1) / 2;
  localparam int PER      = LAT + 4;
  localparam int DONE_CYC = 2 + PAIRS * PER;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] body_addr;
  logic [AW-1:0] acc_addr = '0;
  logic [FW-1:0] body_x = '0, body_y = '0, body_m = '0;
  logic [FW-1:0] g_x1, g_y1, g_m1, g_x2, g_y2, g_m2;
  logic [FW-1:0] g_x1old_psum, g_y1old_psum, g_x2old_psum, g_y2old_psum;
  logic [FW-1:0] g_x1new_psum, g_y1new_psum, g_x2new_psum, g_y2new_psum;
  logic [FW-1:0] acc_ax, acc_ay;

  always #5 clk = ~clk;

  grav_pair_sched #(
    .N_BODIES (N),
    .GRAV_LAT (LAT),
    .FP_W     (FW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .body_addr    (body_addr),
    .body_x       (body_x),
    .body_y       (body_y),
    .body_m       (body_m),
    .g_x1         (g_x1),
    .g_y1         (g_y1),
    .g_m1         (g_m1),
    .g_x2         (g_x2),
    .g_y2         (g_y2),
    .g_m2         (g_m2),
    .g_x1old_psum (g_x1old_psum),
    .g_y1old_psum (g_y1old_psum),
    .g_x2old_psum (g_x2old_psum),
    .g_y2old_psum (g_y2old_psum),
    .g_x1new_psum (g_x1new_psum),
    .g_y1new_psum (g_y1new_psum),
    .g_x2new_psum (g_x2new_psum),
    .g_y2new_psum (g_y2new_psum),
    .acc_addr     (acc_addr),
    .acc_ax       (acc_ax),
    .acc_ay       (acc_ay)
  );

  // Body store: registered read, x=i+10, y=i+20, m=i+30.
  always @(posedge clk) begin
    body_x <= FW'(body_addr) + FW'(10);
    body_y <= FW'(body_addr) + FW'(20);
    body_m <= FW'(body_addr) + FW'(30);
  end

  // Stub grav: LAT-deep pipeline of integer increments.
  logic [4*FW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {g_x1old_psum + FW'(1), g_y1old_psum + FW'(1),
                g_x2old_psum + FW'(2), g_y2old_psum + FW'(2)};
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign {g_x1new_psum, g_y1new_psum, g_x2new_psum, g_y2new_psum} = pipe[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  logic [AW-1:0]  exp_addr [$];
  logic [10*FW-1:0] exp_g  [$];
  int m_ax [N];
  int m_ay [N];

  function automatic logic [10*FW-1:0] dut_g();
    return {g_x1, g_y1, g_m1, g_x2, g_y2, g_m2,
            g_x1old_psum, g_y1old_psum, g_x2old_psum, g_y2old_psum};
  endfunction

  task automatic load_model();
    exp_addr.delete();
    exp_g.delete();
    for (int n = 0; n < N; n++) begin
      m_ax[n] = 0;
      m_ay[n] = 0;
    end
    for (int i = 0; i < N - 1; i++) begin
      for (int j = i + 1; j < N; j++) begin
        exp_addr.push_back(AW'(i));
        exp_addr.push_back(AW'(j));
        exp_g.push_back({FW'(i + 10), FW'(i + 20), FW'(i + 30),
                         FW'(j + 10), FW'(j + 20), FW'(j + 30),
                         FW'(m_ax[i]), FW'(m_ay[i]), FW'(m_ax[j]), FW'(m_ay[j])});
        m_ax[i] += 1;
        m_ay[i] += 1;
        m_ax[j] += 2;
        m_ay[j] += 2;
      end
    end
  endtask

  task automatic sweep_acc(input string tag);
    for (int a = 0; a < N; a++) begin
      acc_addr = AW'(a);
      #1;
      chk({tag, "_ax"}, acc_ax, FW'(m_ax[a]));
      chk({tag, "_ay"}, acc_ay, FW'(m_ay[a]));
    end
    acc_addr = '0;
  endtask

  // Cycle k is the one ending at edge k; start sampled at edge 0.
  task automatic run_pass(input int s_lo, input int s_hi, input int s_done, input int abort_at);
    logic [10*FW-1:0] cur_g;
    int off;
    cur_g = '0;
    load_model();
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= DONE_CYC + 1; k++) begin
      @(negedge clk);
      chk("busy", busy, k <= DONE_CYC);
      chk("done", done, k == DONE_CYC);
      if (k >= 2 && k < DONE_CYC) begin
        off = (k - 2) % PER;
        if (off < 2) begin
          if (exp_addr.size() == 0) chk("addr_sb_empty", exp_addr.size(), 1);
          else chk("body_addr", body_addr, exp_addr.pop_front());
        end else if (off >= 3 && off < 3 + LAT) begin
          if (off == 3) begin
            if (exp_g.size() == 0) chk("g_sb_empty", exp_g.size(), 1);
            else cur_g = exp_g.pop_front();
          end
          chk("g_outputs", dut_g(), cur_g);
        end
      end
      if (k == abort_at) begin
        start = 1'b0;
        rst   = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", body_addr, 0);
        chk("rst_g", dut_g(), 0);
        chk("rst_acc", {acc_ax, acc_ay}, 0);
        @(negedge clk);
        chk("rst_hold_done", done, 0);
        rst = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("post_rst_done", done, 0);
          chk("post_rst_busy", busy, 0);
        end
        exp_addr.delete();
        exp_g.delete();
        return;
      end
      start = ((k >= s_lo) && (k <= s_hi)) || (k == s_done);
    end
    start = 1'b0;
    chk("addr_sb_left", exp_addr.size(), 0);
    chk("g_sb_left", exp_g.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_addr", body_addr, 0);
    chk("reset_g", dut_g(), 0);
    for (int n = 0; n < N; n++) begin
      m_ax[n] = 0;
      m_ay[n] = 0;
    end
    sweep_acc("reset_acc");
    rst = 1'b1;
    @(negedge clk);

    run_pass(-1, -2, -1, -1);
    sweep_acc("passA_acc");
    repeat (20) @(negedge clk);
    sweep_acc("hold_acc");

    run_pass(50, 60, DONE_CYC, -1);
    sweep_acc("restart_acc");

    run_pass(-1, -2, -1, 30);
    run_pass(-1, -2, -1, -1);
    sweep_acc("after_rst_acc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
